ascon_fsm: RTL and testbench

- Moore control FSM for the ASCON-128 encryption datapath. It sequences initialisation, associated-data (AD) absorption, plaintext (PT) encryption and finalisation.
- It drives the round counter through its enable and init inputs, and reads the counter value back as the round index.
- It emits the enables for the state register, the data/key XORs, the ciphertext/tag capture and the done flag.
- It sits directly upstream of the round counter and the permutation datapath, and is the only consumer of the counter output.

---
 rtl/ascon_fsm_pkg.sv | 30 +++
 rtl/ascon_fsm_if.sv | 36 +++
 rtl/ascon_fsm.sv | 181 ++++++++++++++++++
 tb/tb_ascon_fsm.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ascon_fsm_pkg.sv
// ascon_pack: state encoding and round-index constants shared by the
// ASCON-128 control FSM and its bench.
package ascon_pack;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    INIT_START  = 4'd1,
    INIT_ROUNDS = 4'd2,
    AD_WAIT     = 4'd3,
    AD_START    = 4'd4,
    AD_ROUNDS   = 4'd5,
    PT_WAIT     = 4'd6,
    PT_START    = 4'd7,
    PT_ROUNDS   = 4'd8,
    FIN_START   = 4'd9,
    FIN_ROUNDS  = 4'd10,
    DONE        = 4'd11
  } state_t;

  // p12 runs the counter 0..11, p6 runs it 6..11; both end on the same index
  localparam logic [3:0] ROUND_P12_FIRST = 4'd0;
  localparam logic [3:0] ROUND_P6_FIRST  = 4'd6;
  localparam logic [3:0] ROUND_LAST      = 4'd11;

  // Width of a block counter that must hold 0..n-1 (at least one bit)
  function automatic int blk_cnt_w(input int n);
    return $clog2((n > 2) ? n : 2);
  endfunction

endpackage

// File: rtl/ascon_fsm_if.sv
// Control bundle between the ASCON FSM and its surroundings: message
// handshake, round-counter link and datapath enables.
interface ascon_fsm_if;
  logic       start_i;
  logic       data_valid_i;
  logic [3:0] cpt_i;
  logic       en_cpt_o;
  logic       init_p12_o;
  logic       init_p6_o;
  logic       init_state_o;
  logic       en_reg_state_o;
  logic       en_xor_data_o;
  logic       en_xor_key_begin_o;
  logic       en_xor_key_end_o;
  logic       en_xor_lsb_o;
  logic       en_cipher_o;
  logic       en_tag_o;
  logic       cipher_valid_o;
  logic       end_o;

  // Environment side: drives message handshake and the counter value
  modport master (
    output start_i, data_valid_i, cpt_i,
    input  en_cpt_o, init_p12_o, init_p6_o, init_state_o, en_reg_state_o,
           en_xor_data_o, en_xor_key_begin_o, en_xor_key_end_o, en_xor_lsb_o,
           en_cipher_o, en_tag_o, cipher_valid_o, end_o
  );

  // FSM side
  modport slave (
    input  start_i, data_valid_i, cpt_i,
    output en_cpt_o, init_p12_o, init_p6_o, init_state_o, en_reg_state_o,
           en_xor_data_o, en_xor_key_begin_o, en_xor_key_end_o, en_xor_lsb_o,
           en_cipher_o, en_tag_o, cipher_valid_o, end_o
  );
endinterface

// File: rtl/ascon_fsm.sv
// ASCON-128 encryption control FSM (Moore). Sequences init (p12), AD
// absorption (p6 per block), PT encryption (p6 per block, last block goes
// straight to finalisation) and finalisation (p12). The round counter is
// external; this block loads/enables it and decodes its index.
module ascon_fsm
  import ascon_pack::*;
#(
  parameter int NB_AD_BLOCKS = 1,
  parameter int NB_PT_BLOCKS = 4
) (
  input logic        clock_i,
  input logic        resetb_i,
  ascon_fsm_if.slave io_bus
);

  localparam int AD_W = blk_cnt_w(NB_AD_BLOCKS);
  localparam int PT_W = blk_cnt_w(NB_PT_BLOCKS);
  localparam logic [AD_W-1:0] AD_LAST = AD_W'(NB_AD_BLOCKS - 1);
  localparam logic [PT_W-1:0] PT_LAST = PT_W'(NB_PT_BLOCKS - 1);

  state_t          r_state, w_next;
  logic [AD_W-1:0] r_ad_cnt;
  logic [PT_W-1:0] r_pt_cnt;

  logic w_round_last, w_ad_last, w_pt_last;
  logic w_en_cpt, w_init_p12, w_init_p6, w_init_state, w_en_reg_state;
  logic w_xor_data, w_xor_key_begin, w_xor_key_end, w_xor_lsb;
  logic w_en_cipher, w_en_tag, w_cipher_valid, w_end;

  assign w_round_last = (io_bus.cpt_i == ROUND_LAST);
  assign w_ad_last    = (r_ad_cnt == AD_LAST);
  assign w_pt_last    = (r_pt_cnt == PT_LAST);

  // State register
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) r_state <= IDLE;
    else           r_state <= w_next;
  end

  // Block counters: advance at the last round of each block, cleared when
  // their phase is left so a new message starts from block 0
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_ad_cnt <= '0;
      r_pt_cnt <= '0;
    end else if (w_round_last) begin
      case (r_state)
        AD_ROUNDS:  r_ad_cnt <= w_ad_last ? '0 : r_ad_cnt + 1'b1;
        PT_ROUNDS:  r_pt_cnt <= r_pt_cnt + 1'b1;
        FIN_ROUNDS: r_pt_cnt <= '0;
        default: ;
      endcase
    end
  end

  // Next state and Moore output decode (state + round index)
  always_comb begin
    w_next          = r_state;
    w_en_cpt        = 1'b0;
    w_init_p12      = 1'b0;
    w_init_p6       = 1'b0;
    w_init_state    = 1'b0;
    w_en_reg_state  = 1'b0;
    w_xor_data      = 1'b0;
    w_xor_key_begin = 1'b0;
    w_xor_key_end   = 1'b0;
    w_xor_lsb       = 1'b0;
    w_en_cipher     = 1'b0;
    w_en_tag        = 1'b0;
    w_cipher_valid  = 1'b0;
    w_end           = 1'b0;
    case (r_state)
      IDLE: if (io_bus.start_i) w_next = INIT_START;

      INIT_START: begin
        w_en_cpt   = 1'b1;
        w_init_p12 = 1'b1;
        w_next     = INIT_ROUNDS;
      end

      INIT_ROUNDS: begin
        w_en_cpt       = 1'b1;
        w_en_reg_state = 1'b1;
        // first round takes IV||K||N instead of the state register
        if (io_bus.cpt_i == ROUND_P12_FIRST) w_init_state = 1'b1;
        if (w_round_last) begin
          w_xor_key_end = 1'b1;
          w_next        = AD_WAIT;
        end
      end

      AD_WAIT: if (io_bus.data_valid_i) w_next = AD_START;

      AD_START: begin
        w_en_cpt  = 1'b1;
        w_init_p6 = 1'b1;
        w_next    = AD_ROUNDS;
      end

      AD_ROUNDS: begin
        w_en_cpt       = 1'b1;
        w_en_reg_state = 1'b1;
        if (io_bus.cpt_i == ROUND_P6_FIRST) w_xor_data = 1'b1;
        if (w_round_last) begin
          if (w_ad_last) begin
            // domain separation between AD and PT
            w_xor_lsb = 1'b1;
            w_next    = PT_WAIT;
          end else begin
            w_next    = AD_WAIT;
          end
        end
      end

      PT_WAIT: begin
        if (io_bus.data_valid_i) w_next = w_pt_last ? FIN_START : PT_START;
      end

      PT_START: begin
        // ciphertext = rate XOR PT is available before the permutation
        w_en_cipher    = 1'b1;
        w_cipher_valid = 1'b1;
        w_en_cpt       = 1'b1;
        w_init_p6      = 1'b1;
        w_next         = PT_ROUNDS;
      end

      PT_ROUNDS: begin
        w_en_cpt       = 1'b1;
        w_en_reg_state = 1'b1;
        if (io_bus.cpt_i == ROUND_P6_FIRST) w_xor_data = 1'b1;
        if (w_round_last) w_next = PT_WAIT;
      end

      FIN_START: begin
        // last PT block: capture its ciphertext, then run p12
        w_en_cipher    = 1'b1;
        w_cipher_valid = 1'b1;
        w_en_cpt       = 1'b1;
        w_init_p12     = 1'b1;
        w_next         = FIN_ROUNDS;
      end

      FIN_ROUNDS: begin
        w_en_cpt       = 1'b1;
        w_en_reg_state = 1'b1;
        if (io_bus.cpt_i == ROUND_P12_FIRST) begin
          w_xor_data      = 1'b1;
          w_xor_key_begin = 1'b1;
        end
        if (w_round_last) begin
          w_xor_key_end = 1'b1;
          w_en_tag      = 1'b1;
          w_next        = DONE;
        end
      end

      DONE: begin
        w_end  = 1'b1;
        w_next = IDLE;
      end

      default: w_next = IDLE;
    endcase
  end

  assign io_bus.en_cpt_o           = w_en_cpt;
  assign io_bus.init_p12_o         = w_init_p12;
  assign io_bus.init_p6_o          = w_init_p6;
  assign io_bus.init_state_o       = w_init_state;
  assign io_bus.en_reg_state_o     = w_en_reg_state;
  assign io_bus.en_xor_data_o      = w_xor_data;
  assign io_bus.en_xor_key_begin_o = w_xor_key_begin;
  assign io_bus.en_xor_key_end_o   = w_xor_key_end;
  assign io_bus.en_xor_lsb_o       = w_xor_lsb;
  assign io_bus.en_cipher_o        = w_en_cipher;
  assign io_bus.en_tag_o           = w_en_tag;
  assign io_bus.cipher_valid_o     = w_cipher_valid;
  assign io_bus.end_o              = w_end;

endmodule

// File: tb/tb_ascon_fsm.sv
// Bench for ascon_fsm: two instances (1 AD / 4 PT and 3 AD / 1 PT), each
// with a behavioural round counter. Expected output pulses are queued as
// (cycle, output) events; a negedge monitor pops and compares them.
// Cycle k is the clock period ending at the k-th rising edge after the one
// that sampled start_i.
module tb_ascon_fsm;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  ascon_fsm_if if0 ();
  ascon_fsm_if if1 ();

  ascon_fsm #(.NB_AD_BLOCKS(1), .NB_PT_BLOCKS(4)) u_dut0 (
    .clock_i(clk), .resetb_i(resetb), .io_bus(if0.slave));
  ascon_fsm #(.NB_AD_BLOCKS(3), .NB_PT_BLOCKS(1)) u_dut1 (
    .clock_i(clk), .resetb_i(resetb), .io_bus(if1.slave));

  // behavioural round counters
  logic [3:0] cpt0 = 4'd0, cpt1 = 4'd0;
  always @(posedge clk) begin
    if (if0.init_p12_o)     cpt0 <= 4'd0;
    else if (if0.init_p6_o) cpt0 <= 4'd6;
    else if (if0.en_cpt_o)  cpt0 <= cpt0 + 4'd1;
    if (if1.init_p12_o)     cpt1 <= 4'd0;
    else if (if1.init_p6_o) cpt1 <= 4'd6;
    else if (if1.en_cpt_o)  cpt1 <= cpt1 + 4'd1;
  end
  assign if0.cpt_i = cpt0;
  assign if1.cpt_i = cpt1;

  wire [12:0] outs0 = {if0.en_cpt_o, if0.init_p12_o, if0.init_p6_o, if0.init_state_o,
    if0.en_reg_state_o, if0.en_xor_data_o, if0.en_xor_key_begin_o, if0.en_xor_key_end_o,
    if0.en_xor_lsb_o, if0.en_cipher_o, if0.en_tag_o, if0.cipher_valid_o, if0.end_o};
  wire [12:0] outs1 = {if1.en_cpt_o, if1.init_p12_o, if1.init_p6_o, if1.init_state_o,
    if1.en_reg_state_o, if1.en_xor_data_o, if1.en_xor_key_begin_o, if1.en_xor_key_end_o,
    if1.en_xor_lsb_o, if1.en_cipher_o, if1.en_tag_o, if1.cipher_valid_o, if1.end_o};

  // monitored pulse outputs, bit index = event code
  localparam int C_INIT = 0, C_XD = 1, C_KB = 2, C_KE = 3, C_LSB = 4, C_CV = 5, C_TAG = 6, C_END = 7;
  wire [7:0] ev0 = {if0.end_o, if0.en_tag_o, if0.cipher_valid_o, if0.en_xor_lsb_o,
    if0.en_xor_key_end_o, if0.en_xor_key_begin_o, if0.en_xor_data_o, if0.init_state_o};
  wire [7:0] ev1 = {if1.end_o, if1.en_tag_o, if1.cipher_valid_o, if1.en_xor_lsb_o,
    if1.en_xor_key_end_o, if1.en_xor_key_begin_o, if1.en_xor_data_o, if1.init_state_o};

  typedef struct { int lbl; int code; } ev_t;
  ev_t q0[$];
  ev_t q1[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, s0 = -1000, s1 = -1000;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input int w, input int l, input int c);
    ev_t e;
    e.lbl = l; e.code = c;
    if (w == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // monitor: every asserted pulse output must match the next queued event
  task automatic mon(input int w, input logic [7:0] ev, input int lbl);
    ev_t e;
    for (int c = 0; c < 8; c++) begin
      if (ev[c]) begin
        n_cmp++;
        if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
          n_err++;
          $display("FAIL unexpected_event dut%0d: got code %0d at cycle %0d, expected none", w, c, lbl);
        end else begin
          e = (w == 0) ? q0.pop_front() : q1.pop_front();
          if (e.lbl != lbl || e.code != c) begin
            n_err++;
            $display("FAIL event dut%0d: got code %0d at cycle %0d, expected code %0d at cycle %0d",
                     w, c, lbl, e.code, e.lbl);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (resetb) begin
      mon(0, ev0, cyc - s0);
      mon(1, ev1, cyc - s1);
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  // full 1-AD/4-PT message; a = AD_WAIT stall, b = total stall after 2nd PT_WAIT
  task automatic push_main(input int a, input int b);
    push(0, 2, C_INIT);       push(0, 13, C_KE);
    push(0, 16 + a, C_XD);    push(0, 21 + a, C_LSB);
    push(0, 23 + a, C_CV);    push(0, 24 + a, C_XD);
    push(0, 31 + b, C_CV);    push(0, 32 + b, C_XD);
    push(0, 39 + b, C_CV);    push(0, 40 + b, C_XD);
    push(0, 47 + b, C_CV);    push(0, 48 + b, C_XD);
    push(0, 48 + b, C_KB);    push(0, 59 + b, C_KE);
    push(0, 59 + b, C_TAG);   push(0, 60 + b, C_END);
  endtask

  // mode 0: plain, 1: back-pressure, 2: ignored inputs, 3: reset at PT_ROUNDS cpt 8
  task automatic run_main(input int mode);
    int k, last;
    last = (mode == 1) ? 72 : (mode == 3) ? 26 : 62;
    if0.data_valid_i = 1'b1;
    tick();
    if0.start_i = 1'b1; s0 = cyc;
    tick();
    if0.start_i = 1'b0;
    k = cyc - s0;
    while (k < last) begin
      tick();
      k = cyc - s0;
      if0.data_valid_i = 1'b1;
      if0.start_i      = 1'b0;
      if (mode == 1 && ((k >= 14 && k <= 18) || (k >= 35 && k <= 39))) if0.data_valid_i = 1'b0;
      if (mode == 1 && (k == 16 || k == 37)) chk("hold_en_cpt", 32'(if0.en_cpt_o), 32'd0);
      if (mode == 2 && k >= 3 && k <= 6) if0.data_valid_i = (k % 2 == 1);
      if (mode == 2 && (k == 5 || k == 60)) if0.start_i = 1'b1;
    end
    if (mode == 3) begin
      chk("abort_cpt", 32'(cpt0), 32'd8);
      resetb = 1'b0;
      #1;
      chk("abort_outs_zero", 32'(outs0), 32'd0);
      chk("abort_queue_empty", 32'(q0.size()), 32'd0);
      tick(); tick();
      chk("abort_hold_zero", 32'(outs0), 32'd0);
      resetb = 1'b1;
    end else begin
      chk("idle_after_msg", 32'(outs0), 32'd0);
      chk("queue0_drained", 32'(q0.size()), 32'd0);
    end
  endtask

  initial begin
    if0.start_i = 1'b0; if0.data_valid_i = 1'b0;
    if1.start_i = 1'b0; if1.data_valid_i = 1'b1;
    #12;
    chk("reset_outs0", 32'(outs0), 32'd0);
    chk("reset_outs1", 32'(outs1), 32'd0);
    tick();
    resetb = 1'b1;
    tick();
    chk("idle_outs0", 32'(outs0), 32'd0);

    push_main(0, 0);
    run_main(0);

    push_main(5, 10);
    run_main(1);

    push_main(0, 0);
    run_main(2);

    push(0, 2, C_INIT); push(0, 13, C_KE); push(0, 16, C_XD);
    push(0, 21, C_LSB); push(0, 23, C_CV); push(0, 24, C_XD);
    run_main(3);
    push_main(0, 0);
    run_main(0);

    // 3 AD blocks, 1 PT block: single ciphertext pulse comes from FIN_START
    push(1, 2, C_INIT);  push(1, 13, C_KE);  push(1, 16, C_XD);
    push(1, 24, C_XD);   push(1, 32, C_XD);  push(1, 37, C_LSB);
    push(1, 39, C_CV);   push(1, 40, C_XD);  push(1, 40, C_KB);
    push(1, 51, C_KE);   push(1, 51, C_TAG); push(1, 52, C_END);
    tick();
    if1.start_i = 1'b1; s1 = cyc;
    tick();
    if1.start_i = 1'b0;
    while (cyc - s1 < 54) tick();
    chk("idle_after_sweep", 32'(outs1), 32'd0);
    chk("queue1_drained", 32'(q1.size()), 32'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
